// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       busy,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic rr, acc, done, fire;
  logic [3:0] cnt;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // grant, handshakes and next state; rr=1 means req1 wins a tie
  always_comb begin
    req0_ready = state == IDLE && req0_valid && (!req1_valid || !rr);
    req1_ready = state == IDLE && req1_valid && (!req0_valid || rr);
    acc = req0_ready || req1_ready;
    done = state == EXEC && cnt == 4'd0;
    fire = state == RESP && rsp_valid && rsp_ready;
    state_nx = state == IDLE ? (acc ? EXEC : IDLE) :
               state == EXEC ? (done ? RESP : EXEC) :
               (fire ? IDLE : RESP);
  end
  // operand latch, exec countdown, result capture and completion count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr <= 1'b0;
      cnt <= 4'd0;
      alu_a <= 4'd0;
      alu_b <= 4'd0;
      alu_opcode <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= 8'd0;
      rsp_carry <= 1'b0;
      op_count <= 8'd0;
    end else begin
      if (acc) begin
        alu_a <= req1_ready ? req1_a : req0_a;
        alu_b <= req1_ready ? req1_b : req0_b;
        alu_opcode <= req1_ready ? req1_op : req0_op;
        rsp_id <= req1_ready;
        rr <= !req1_ready;
        cnt <= 4'(EXEC_CYCLES - 1);
      end
      if (state == EXEC && !done) cnt <= cnt - 4'd1;
      if (done) begin
        rsp_result <= alu_result;
        rsp_carry <= alu_carry;
        rsp_valid <= 1'b1;
      end
      if (fire) begin
        rsp_valid <= 1'b0;
        op_count <= op_count + 8'd1;
      end
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of the arbiter with a stub ALU, EXEC_CYCLES of 1 and 3
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready, rsp_ready = 1;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, alu_a, alu_b;
  logic [2:0] req0_op = 0, req1_op = 0, alu_opcode;
  logic [7:0] alu_result, rsp_result, op_count;
  logic alu_carry, rsp_valid, rsp_id, rsp_carry, busy;
  logic req0_valid_3 = 0, req1_valid_3 = 0, req0_ready_3, req1_ready_3, rsp_ready_3 = 0;
  logic [3:0] req0_a_3 = 0, req0_b_3 = 0, req1_a_3 = 0, req1_b_3 = 0, alu_a_3, alu_b_3;
  logic [2:0] req0_op_3 = 0, req1_op_3 = 0, alu_opcode_3;
  logic [7:0] alu_result_3, rsp_result_3, op_count_3;
  logic alu_carry_3, rsp_valid_3, rsp_id_3, rsp_carry_3, busy_3;
  always #5 clk = ~clk;
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [7:0] p;
    s = {1'b0, a} + {1'b0, b};
    p = {4'd0, a} * {4'd0, b};
    case (op)
      3'd0: alu_f = {s[4], 4'd0, s[3:0]};
      3'd2: alu_f = {1'b0, p};
      3'd7: alu_f = {5'd0, a ^ b};
      default: alu_f = {5'd0, a & b};
    endcase
  endfunction
  assign {alu_carry, alu_result} = alu_f(alu_opcode, alu_a, alu_b);
  assign {alu_carry_3, alu_result_3} = alu_f(alu_opcode_3, alu_a_3, alu_b_3);
  alu_arbiter #(.EXEC_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .busy(busy), .op_count(op_count)
  );
  alu_arbiter #(.EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid_3), .req0_ready(req0_ready_3), .req0_a(req0_a_3), .req0_b(req0_b_3), .req0_op(req0_op_3),
    .req1_valid(req1_valid_3), .req1_ready(req1_ready_3), .req1_a(req1_a_3), .req1_b(req1_b_3), .req1_op(req1_op_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_opcode(alu_opcode_3), .alu_result(alu_result_3), .alu_carry(alu_carry_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_id(rsp_id_3), .rsp_result(rsp_result_3),
    .rsp_carry(rsp_carry_3), .busy(busy_3), .op_count(op_count_3)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    step;
    step;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_op_count", {24'd0, op_count}, 0);
    chk("rst_alu", {21'd0, alu_a, alu_b, alu_opcode}, 0);
    chk("rst_rsp", {22'd0, rsp_id, rsp_carry, rsp_result}, 0);
    rst = 1'b0;
    step;
    // EXEC_CYCLES=3 latency and backpressure hold
    req0_valid_3 = 1; req0_a_3 = 12; req0_b_3 = 7; req0_op_3 = 0;
    #1;
    chk("e3_req0_ready", {31'd0, req0_ready_3}, 1);
    step;
    req0_valid_3 = 0;
    req1_valid_3 = 1; req1_a_3 = 3; req1_b_3 = 3; req1_op_3 = 0;
    #1;
    chk("e3_busy_k", {31'd0, busy_3}, 1);
    chk("e3_alu_a", {28'd0, alu_a_3}, 12);
    chk("e3_req1_ready_exec", {31'd0, req1_ready_3}, 0);
    step;
    chk("e3_valid_k1", {31'd0, rsp_valid_3}, 0);
    step;
    chk("e3_valid_k2", {31'd0, rsp_valid_3}, 0);
    step;
    chk("e3_valid_k3", {31'd0, rsp_valid_3}, 1);
    for (int i = 0; i < 5; i++) begin
      req1_a_3 = 4'(i);
      #1;
      chk("e3_hold_valid", {31'd0, rsp_valid_3}, 1);
      chk("e3_hold_id", {31'd0, rsp_id_3}, 0);
      chk("e3_hold_result", {24'd0, rsp_result_3}, 8'h03);
      chk("e3_hold_carry", {31'd0, rsp_carry_3}, 1);
      chk("e3_hold_readys", {30'd0, req0_ready_3, req1_ready_3}, 0);
      chk("e3_hold_busy", {31'd0, busy_3}, 1);
      if (i < 4) step;
    end
    rsp_ready_3 = 1;
    step;
    chk("e3_done_valid", {31'd0, rsp_valid_3}, 0);
    chk("e3_done_count", {24'd0, op_count_3}, 1);
    chk("e3_done_busy", {31'd0, busy_3}, 0);
    chk("e3_next_req1", {31'd0, req1_ready_3}, 1);
    req1_valid_3 = 0;
    // single requester 0: 9+8
    req0_valid = 1; req0_a = 9; req0_b = 8; req0_op = 0;
    #1;
    chk("t1_ready", {31'd0, req0_ready}, 1);
    step;
    req0_valid = 0;
    #1;
    chk("t1_ready_drop", {31'd0, req0_ready}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    step;
    chk("t1_valid", {31'd0, rsp_valid}, 1);
    chk("t1_id", {31'd0, rsp_id}, 0);
    chk("t1_result", {24'd0, rsp_result}, 8'h01);
    chk("t1_carry", {31'd0, rsp_carry}, 1);
    step;
    chk("t1_count", {24'd0, op_count}, 1);
    chk("t1_idle", {30'd0, busy, rsp_valid}, 0);
    // single requester 1: 15*15
    req1_valid = 1; req1_a = 15; req1_b = 15; req1_op = 2;
    #1;
    chk("t2_ready", {30'd0, req0_ready, req1_ready}, 1);
    step;
    req1_valid = 0;
    step;
    chk("t2_id", {31'd0, rsp_id}, 1);
    chk("t2_result", {24'd0, rsp_result}, 8'hE1);
    chk("t2_carry", {31'd0, rsp_carry}, 0);
    step;
    chk("t2_count", {24'd0, op_count}, 2);
    // both valid from reset: alternating grants
    rst = 1;
    req0_valid = 1; req0_a = 6; req0_b = 2; req0_op = 7;
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 0;
    step;
    rst = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant", {30'd0, req0_ready, req1_ready}, (i % 2) ? 1 : 2);
      step;
      step;
      chk("t3_id", {31'd0, rsp_id}, (i % 2) ? 1 : 0);
      chk("t3_result", {24'd0, rsp_result}, (i % 2) ? 8'h02 : 8'h04);
      chk("t3_carry", {31'd0, rsp_carry}, 0);
      step;
    end
    chk("t3_count", {24'd0, op_count}, 4);
    // reset during EXEC after a req0 grant
    req1_valid = 0; req0_a = 9; req0_b = 8; req0_op = 0;
    step;
    req0_valid = 0;
    chk("t5_in_exec", {31'd0, busy}, 1);
    chk("t5_alu_a", {28'd0, alu_a}, 9);
    rst = 1;
    #1;
    chk("t5_async_busy", {31'd0, busy}, 0);
    chk("t5_async_alu", {21'd0, alu_a, alu_b, alu_opcode}, 0);
    chk("t5_async_rsp", {22'd0, rsp_id, rsp_carry, rsp_result}, 0);
    chk("t5_async_count", {24'd0, op_count}, 0);
    step;
    step;
    chk("t5_no_rsp", {31'd0, rsp_valid}, 0);
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_grant_req0", {30'd0, req0_ready, req1_ready}, 2);
    req1_valid = 0;
    // op_count wrap
    for (int i = 0; i < 255; i++) begin
      step;
      step;
      step;
    end
    chk("t6_count_255", {24'd0, op_count}, 255);
    step;
    step;
    step;
    chk("t6_count_wrap", {24'd0, op_count}, 0);
    req0_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the 4-bit ALU (alu_top) between two requesters. Round-robin arbitration picks one request, latches its operands and opcode, and holds them on the ALU inputs for a fixed number of cycles. It then samples the 8-bit result and carry and returns them on a valid/ready response channel tagged with the requester ID. It sits between the requesting datapath blocks and the combinational ALU, which is instantiated outside this block.

Parameters:
EXEC_CYCLES, 1, cycles the latched operands are held on the ALU inputs before the result is sampled; legal range 1..15.

Ports:
clk  input  1  single clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  4  requester 0 operand A
req0_b  input  4  requester 0 operand B
req0_op  input  3  requester 0 ALU opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and directions as requester 0, for requester 1
alu_a  output  4  to ALU input A
alu_b  output  4  to ALU input B
alu_opcode  output  3  to ALU opcode
alu_result  input  8  from ALU result
alu_carry  input  1  from ALU carry_out
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester the response belongs to (0 or 1)
rsp_result  output  8  sampled ALU result
rsp_carry  output  1  sampled ALU carry
busy  output  1  high whenever state is not IDLE
op_count  output  8  completed-response counter, wraps

Behaviour:
- Reset (asynchronous, while rst high):
  - state=IDLE, rr pointer=req0.
  - alu_a/alu_b/alu_opcode=0; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0.
  - op_count=0, busy=0, exec counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant is combinational:
  - Only one requester valid: grant it.
  - Both valid: grant the requester the rr pointer names.
  - reqN_ready = (state==IDLE) && granted N. The ungranted requester sees ready=0.
- Accept on the edge where reqN_valid && reqN_ready:
  - Latch a/b/op into the alu_* output registers and N into rsp_id.
  - Move the rr pointer to the other requester. The pointer changes only on an accept.
  - Load exec counter with EXEC_CYCLES-1 and go to EXEC.
- EXEC:
  - alu_* hold the latched values.
  - Counter decrements each cycle.
  - On the edge where counter==0: register alu_result/alu_carry into rsp_result/rsp_carry, set rsp_valid=1, go to RESP.
- Latency: accept at edge k gives rsp_valid high after edge k+EXEC_CYCLES.
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - On the edge where rsp_valid && rsp_ready: rsp_valid=0, op_count+1 (255 wraps to 0), go to IDLE.
- No accept in EXEC or RESP; both readys are 0. Minimum spacing between accepts is EXEC_CYCLES+2 cycles when rsp_ready is held high.
- alu_a/alu_b/alu_opcode keep the last latched values in IDLE. They are not cleared.
- Requesters may change operands or drop valid while ready=0; nothing is captured in that case.
- Opcodes are passed through uninterpreted. rsp_carry is whatever the ALU drives for that opcode.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded with no response, and all state returns to reset values immediately.
- busy = (state != IDLE).

Test Plan:
- After reset, only req0 valid, op=000, a=9, b=8, EXEC_CYCLES=1, rsp_ready=1 -> req0_ready pulses for 1 cycle; rsp_valid 1 cycle later with rsp_id=0, rsp_result=0x01, rsp_carry=1; op_count=1.
- req1 only, op=010, a=15, b=15 -> rsp_id=1, rsp_result=0xE1, rsp_carry=0.
- Both valid continuously from reset, req0 op=111 a=6 b=2, req1 op=000 a=1 b=1 -> grants alternate 0,1,0,1. First response is id 0 with result 0x04; second is id 1 with result 0x02.
- EXEC_CYCLES=3, rsp_ready low for 5 cycles after rsp_valid rises -> rsp_valid rises exactly 3 cycles after accept; rsp_id, rsp_result and rsp_carry stay constant; both readys stay 0; busy=1 throughout.
- Assert rst during EXEC -> all outputs return to 0 asynchronously; no response is emitted; the next op after release is granted to req0.
- Complete 256 operations -> op_count reads 255 after the 255th and 0 after the 256th.
